// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The optional alignment check is enabled with FETCH_ALIGN_CHECK_EN.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } fetch_state_e;

  localparam int          DATA_W    = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry holding register that presents a fetched instruction and its PC
// to decode; flush and accept both empty it, load fills it.
module fetch_out_buf
  import fetch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              accept,
  input  logic              flush,
  input  logic [DATA_W-1:0] instr_d,
  input  logic [DATA_W-1:0] pc_d,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (flush || accept) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_d;
      pc    <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, req/gnt/rvalid memory sequencing and
// redirect handling. Define FETCH_ALIGN_CHECK_EN to add misalign_o and
// force redirect targets onto a word boundary.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  input  logic [31:0] pc_plus4_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        misalign_o,
`endif
  input  logic        instr_ready_i
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  redir_pc;
  logic         redir_act;
  logic         buf_load, buf_accept, buf_flush;

  assign redir_act   = redirect_valid_i && (state_q != S_IDLE);
  assign pc_o        = pc_q;
  assign imem_req_o  = (state_q == S_REQ);
  assign imem_addr_o = imem_req_o ? pc_q : 32'h0;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  assign redir_pc   = {redirect_pc_i[31:2], 2'b00};
  assign misalign_o = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (redir_act && (redirect_pc_i[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end
`else
  assign redir_pc = redirect_pc_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    buf_load   = 1'b0;
    buf_accept = 1'b0;
    buf_flush  = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_plus4_i;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          buf_load = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready_i) begin
          buf_accept = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid_i) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    // Redirect wins; an in-flight response that has not yet arrived must be drained.
    if (redir_act) begin
      pc_d      = redir_pc;
      buf_load  = 1'b0;
      buf_flush = 1'b1;
      if ((state_q == S_REQ && imem_gnt_i) ||
          ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_rvalid_i)) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_REQ;
      end
    end
  end

  fetch_out_buf #(.DATA_W(DATA_W)) u_out_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (buf_load),
    .accept  (buf_accept),
    .flush   (buf_flush),
    .instr_d (imem_rdata_i),
    .pc_d    (req_pc_q),
    .valid   (instr_valid_o),
    .instr   (instr_o),
    .pc      (instr_pc_o)
  );

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage. Owns the program counter and drives it into the PC+4 adder (pc_o feeds adder input a; adder input b is tied to 32'd4).
- Consumes the adder's sum as the sequential next PC.
- Issues word requests to instruction memory over a req/gnt/rvalid protocol.
- Presents fetched instructions to decode through a one-entry valid/ready buffer. Branch and jump redirects override the sequential flow.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- pc_o  out  32  current PC, drives adder input a
- pc_plus4_i  in  32  adder sum, equal to pc_o + 4 combinationally
- redirect_valid_i  in  1  redirect request from execute
- redirect_pc_i  in  32  redirect target
- imem_req_o  out  1  memory request
- imem_addr_o  out  32  request address
- imem_gnt_i  in  1  request accepted
- imem_rvalid_i  in  1  response valid
- imem_rdata_i  in  32  response instruction
- instr_valid_o  out  1  instruction available to decode
- instr_o  out  32  instruction
- instr_pc_o  out  32  PC of instr_o
- instr_ready_i  in  1  decode accepts

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, rst_n.
- Reset values: pc_q=RESET_PC, state=S_IDLE, imem_req_o=0, instr_valid_o=0, instr_o=32'h0000_0013 (NOP), instr_pc_o=0, req_pc_q=0.
- pc_o = pc_q, combinational.
- imem_addr_o = pc_q while imem_req_o=1, else 0.
- States:
  - S_IDLE: entered only from reset; goes to S_REQ on the first clock after reset release.
  - S_REQ: imem_req_o=1; req and addr hold stable until gnt. On gnt: req_pc_q<=pc_q, pc_q<=pc_plus4_i, go to S_WAIT.
  - S_WAIT: imem_req_o=0. On rvalid: instr_o<=imem_rdata_i, instr_pc_o<=req_pc_q, instr_valid_o<=1, go to S_HOLD.
  - S_HOLD: instr_valid_o=1; instr_o and instr_pc_o hold stable. On instr_ready_i: instr_valid_o<=0, go to S_REQ. The next request asserts the cycle after the handshake.
  - S_DRAIN: imem_req_o=0. Waits for rvalid, discards the data, goes to S_REQ.
- Latency:
  - Minimum 2 cycles from request to instr_valid_o (gnt in the first cycle, rvalid in the next).
  - Minimum spacing between instructions is 3 cycles.
- Redirect has the highest priority and is acted on in every state except S_IDLE:
  - pc_q<=redirect_pc_i; pc_plus4_i is ignored that cycle.
  - instr_valid_o<=0 on the next edge. A simultaneous instr_ready_i handshake still counts as consumed.
  - Next state:
    - S_DRAIN if a response is outstanding and not arriving this cycle: S_WAIT without rvalid, or S_REQ with gnt.
    - S_REQ in every other case, including S_WAIT with rvalid the same cycle (that data is dropped).
  - Redirect during S_DRAIN: pc_q updates to the new target, state stays in S_DRAIN.
- Responses:
  - Exactly one rvalid per gnt.
  - rvalid is never expected in S_REQ, S_HOLD or S_IDLE; if it arrives there, ignore it.
- Arithmetic: PC wraps modulo 2^32 (32'hFFFF_FFFC + 4 → 0); no overflow flag.
- Reset mid-transaction: all state cleared immediately, including any outstanding response, which is forgotten.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds port misalign_o (out, 1).
  - A redirect with redirect_pc_i[1:0]!=0 sets misalign_o=1, sticky until reset.
  - pc_q loads {redirect_pc_i[31:2],2'b00}.
- Undefined:
  - No misalign_o port.
  - redirect_pc_i loads verbatim.

Decomposition:
- Package fetch_pkg:
  - fetch_state_e enum (S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN)
  - NOP_INSTR=32'h0000_0013
  - PC_STEP=32'd4
- Sub-module fetch_out_buf: one-entry instruction/PC holding register with load, accept and flush inputs, producing valid, instr and pc.
- The PC+4 adder is instantiated by the parent, not inside this block.

Test Plan:
- Reset release, gnt and rvalid each one cycle after req, instr_ready_i=1 constant → addresses 0x0, 0x4, 0x8 issued; instr_pc_o 0x0, 0x4, 0x8 paired with the matching rdata.
- instr_ready_i=0 for 5 cycles while in S_HOLD → instr_o and instr_pc_o stable, imem_req_o=0, no new request until ready is seen.
- Redirect to 0x100 in S_WAIT without rvalid → S_DRAIN; next rvalid discarded; next request address is 0x100; instr_valid_o never shows the stale word.
- Redirect to 0x200 in S_REQ coincident with gnt → exactly one response discarded; next address 0x200.
- RESET_PC=32'hFFFF_FFFC → first fetch at 0xFFFFFFFC, second at 0x0.
- With FETCH_ALIGN_CHECK_EN defined, redirect to 0x103 → next address 0x100; misalign_o=1, held until rst_n asserted.
